// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-array control path:
// widths, opcodes and sequencer states.
package ca_pkg;

    localparam int PC_W    = 12;
    localparam int SP_W    = 5;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_JDC  = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        FAULT
    } seq_state_t;

    function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] ins);
        return ins[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/simd_sequencer_if.sv
// Bundle between the sequencer, its program ROM and the cell array.
// master = sequencer side, slave = ROM/array side.
interface simd_sequencer_if;
    import ca_pkg::*;

    logic               start;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instruction;
    logic               execution_enable;
    logic [PC_W-1:0]    next_program_counter;
    logic [SP_W-1:0]    next_stack_pointer;
    logic               diverge_consensus;
    logic               busy;
    logic               halted;
    logic               fault;
    logic [31:0]        retired;

    modport master (
        input  start, rom_data, diverge_consensus,
        output rom_addr, instruction, execution_enable,
        output next_program_counter, next_stack_pointer,
        output busy, halted, fault, retired
    );

    modport slave (
        output start, rom_data, diverge_consensus,
        input  rom_addr, instruction, execution_enable,
        input  next_program_counter, next_stack_pointer,
        input  busy, halted, fault, retired
    );

endinterface

// File: rtl/call_stack.sv
// Return-address register file: synchronous push at sp,
// combinational read of the top entry at sp-1.
module call_stack
    import ca_pkg::*;
(
    input  logic            clk,
    input  logic [SP_W-1:0] sp_i,
    input  logic            we_i,
    input  logic [PC_W-1:0] wdata_i,
    output logic [PC_W-1:0] rdata_o
);

    logic [PC_W-1:0] mem_q [2**SP_W];
    logic [SP_W-1:0] top;

    assign top = sp_i - 1'b1;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[sp_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[top];

endmodule

// File: rtl/simd_sequencer.sv
// Fetch/broadcast control unit: PC, return stack and
// control-flow resolution for the cell array.
module simd_sequencer
    import ca_pkg::*;
#(
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input logic              clk,
    input logic              rst,
    simd_sequencer_if.master bus
);

    localparam logic [SP_W-1:0] SP_MAX = '1;

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [31:0]     ret_q, ret_d;

    logic               strobe;
    logic               push;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         op;
    logic [PC_W-1:0]    tgt;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    stk_top;

    assign op     = opcode(bus.rom_data);
    assign tgt    = bus.rom_data[PC_W-1:0];
    assign pc_inc = pc_q + 1'b1;

    call_stack u_stack (
        .clk     (clk),
        .sp_i    (sp_q),
        .we_i    (push && !rst),
        .wdata_i (pc_inc),
        .rdata_o (stk_top)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ret_d   = ret_q;
        strobe  = 1'b0;
        push    = 1'b0;
        instr   = '0;
        unique case (state_q)
            IDLE, HALTED, FAULT: begin
                if (bus.start) begin
                    state_d = FETCH;
                    pc_d    = START_ADDR;
                    sp_d    = '0;
                    ret_d   = '0;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                instr   = bus.rom_data;
                state_d = FETCH;
                strobe  = 1'b1;
                pc_d    = pc_inc;
                unique case (op)
                    OP_HALT: begin
                        strobe  = 1'b0;
                        pc_d    = pc_q;
                        state_d = HALTED;
                    end
                    OP_JMP: pc_d = tgt;
                    OP_JDC: begin
                        if (bus.diverge_consensus) pc_d = tgt;
                    end
                    OP_CALL: begin
                        if (sp_q == SP_MAX) begin
                            strobe  = 1'b0;
                            pc_d    = pc_q;
                            state_d = FAULT;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                            pc_d = tgt;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            strobe  = 1'b0;
                            pc_d    = pc_q;
                            state_d = FAULT;
                        end else begin
                            sp_d = sp_q - 1'b1;
                            pc_d = stk_top;
                        end
                    end
                    default: ;
                endcase
                if (strobe) ret_d = ret_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ret_q   <= ret_d;
        end
    end

    // A reset arriving in EXEC suppresses that cycle's commit.
    assign bus.execution_enable     = strobe && !rst;
    assign bus.instruction          = instr;
    assign bus.rom_addr             = pc_q;
    assign bus.next_program_counter = pc_d;
    assign bus.next_stack_pointer   = sp_d;
    assign bus.busy                 = (state_q == FETCH) || (state_q == EXEC);
    assign bus.halted               = (state_q == HALTED);
    assign bus.fault                = (state_q == FAULT);
    assign bus.retired              = ret_q;

endmodule

// File: tb/tb_simd_sequencer.sv
// Bench for simd_sequencer: ISA-level reference model checked every cycle.
module tb_simd_sequencer;
    import ca_pkg::*;

    typedef enum int {M_IDLE, M_RUN, M_STOP} mode_t;
    typedef struct {
        logic [15:0] instr;
        int npc;
        int nsp;
        int rel;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   dc_mode = 0;

    logic [15:0] rom  [4096];
    logic [15:0] rom2 [4096];

    simd_sequencer_if bus ();
    simd_sequencer_if bus2 ();

    simd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    simd_sequencer #(.START_ADDR(12'hFFF)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
    always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];
    always @(posedge clk) begin
        #1;
        bus.diverge_consensus = (dc_mode == 2) ? 1'($urandom) : 1'(dc_mode);
    end

    mode_t mode = M_IDLE;
    bit    kind_fault;
    int    mpc, msp, mret, exec_cyc, cs;
    int    mstack [32];
    ev_t   log_q [$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_exec();
        logic [15:0] ins;
        int  npc, nsp;
        bit  stb;
        ins = rom[mpc];
        npc = (mpc + 1) % 4096;
        nsp = msp;
        stb = 1;
        kind_fault = 0;
        case (ins[15:12])
            4'hF: stb = 0;
            4'hE: npc = int'(ins[11:0]);
            4'hD: if (bus.diverge_consensus) npc = int'(ins[11:0]);
            4'hC: begin
                if (msp == 31) begin
                    stb = 0;
                    kind_fault = 1;
                end else begin
                    mstack[msp] = (mpc + 1) % 4096;
                    nsp = msp + 1;
                    npc = int'(ins[11:0]);
                end
            end
            4'hB: begin
                if (msp == 0) begin
                    stb = 0;
                    kind_fault = 1;
                end else begin
                    nsp = msp - 1;
                    npc = mstack[nsp];
                end
            end
            default: ;
        endcase
        chk("exec_instr", bus.instruction, ins);
        chk("exec_ee", bus.execution_enable, stb);
        if (stb) begin
            chk("next_pc", bus.next_program_counter, npc);
            chk("next_sp", bus.next_stack_pointer, nsp);
            log_q.push_back('{ins, npc, nsp, cyc - cs + 1});
            mpc = npc;
            msp = nsp;
            mret++;
            exec_cyc += 2;
        end else begin
            mode = M_STOP;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ee", bus.execution_enable, 0);
            mode = M_IDLE;
            mret = 0;
        end else begin
            case (mode)
                M_IDLE: begin
                    chk("idle_busy", bus.busy, 0);
                    chk("idle_halted", bus.halted, 0);
                    chk("idle_fault", bus.fault, 0);
                    chk("idle_ee", bus.execution_enable, 0);
                    chk("idle_instr", bus.instruction, 0);
                    chk("idle_retired", bus.retired, 0);
                    chk("idle_addr", bus.rom_addr, 0);
                end
                M_STOP: begin
                    chk("stop_halted", bus.halted, !kind_fault);
                    chk("stop_fault", bus.fault, kind_fault);
                    chk("stop_busy", bus.busy, 0);
                    chk("stop_ee", bus.execution_enable, 0);
                    chk("stop_instr", bus.instruction, 0);
                    chk("stop_retired", bus.retired, mret);
                end
                default: begin
                    chk("run_busy", bus.busy, 1);
                    chk("run_halted", bus.halted, 0);
                    chk("run_fault", bus.fault, 0);
                    chk("run_addr", bus.rom_addr, mpc);
                    chk("run_retired", bus.retired, mret);
                    if (cyc == exec_cyc) begin
                        model_exec();
                    end else begin
                        chk("fetch_ee", bus.execution_enable, 0);
                        chk("fetch_instr", bus.instruction, 0);
                    end
                end
            endcase
            if (bus.start && mode != M_RUN) begin
                mode = M_RUN;
                mpc = 0;
                msp = 0;
                mret = 0;
                cs = cyc;
                exec_cyc = cyc + 2;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 bus.start = 1'b1;
        @(posedge clk) #1 bus.start = 1'b0;
    endtask

    task automatic wait_stop(int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (mode == M_STOP) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 4096; i++) rom[i] = 16'hF000;
    endtask

    task automatic run_prog(string name, int maxc);
        bit ok;
        log_q.delete();
        pulse_start();
        wait_stop(maxc, ok);
        chk({name, "_done"}, ok, 1);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        bus.start = 1'b0;
        bus.diverge_consensus = 1'b0;
        bus2.start = 1'b0;
        bus2.diverge_consensus = 1'b0;
        fill_halt();
        for (int i = 0; i < 4096; i++) rom2[i] = 16'hF000;
        rom2[12'hFFF] = 16'h1000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_retired", bus.retired, 0);
        chk("reset_addr", bus.rom_addr, 0);
        chk("reset_instr", bus.instruction, 0);

        rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'hF000;
        run_prog("seq", 50);
        chk("seq_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("seq_i0", log_q[0].instr, 16'h1001);
            chk("seq_c0", log_q[0].rel, 3);
            chk("seq_i1", log_q[1].instr, 16'h1002);
            chk("seq_c1", log_q[1].rel, 5);
        end
        chk("seq_halted", bus.halted, 1);
        chk("seq_retired", bus.retired, 2);

        fill_halt();
        rom[0] = 16'hE005; rom[1] = 16'h1111;
        run_prog("jmp", 50);
        chk("jmp_count", log_q.size(), 1);
        if (log_q.size() == 1) chk("jmp_npc", log_q[0].npc, 12'h005);
        chk("jmp_halted", bus.halted, 1);

        fill_halt();
        rom[0] = 16'hD010;
        dc_mode = 0;
        run_prog("jdc0", 50);
        if (log_q.size() == 1) chk("jdc0_npc", log_q[0].npc, 12'h001);
        else chk("jdc0_count", log_q.size(), 1);
        dc_mode = 1;
        run_prog("jdc1", 50);
        if (log_q.size() == 1) chk("jdc1_npc", log_q[0].npc, 12'h010);
        else chk("jdc1_count", log_q.size(), 1);
        dc_mode = 0;

        fill_halt();
        rom[0] = 16'hC020; rom[12'h020] = 16'hB000; rom[1] = 16'hF000;
        run_prog("call", 50);
        chk("call_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("call_npc", log_q[0].npc, 12'h020);
            chk("call_nsp", log_q[0].nsp, 1);
            chk("ret_npc", log_q[1].npc, 12'h001);
            chk("ret_nsp", log_q[1].nsp, 0);
        end
        chk("call_halted", bus.halted, 1);

        fill_halt();
        rom[0] = 16'hC000;
        for (int r = 0; r < 2; r++) begin
            run_prog("nest", 200);
            chk("nest_count", log_q.size(), 31);
            chk("nest_fault", bus.fault, 1);
            chk("nest_retired", bus.retired, 31);
        end

        fill_halt();
        rom[0] = 16'hB000;
        run_prog("under", 50);
        chk("under_count", log_q.size(), 0);
        chk("under_fault", bus.fault, 1);
        chk("under_retired", bus.retired, 0);

        rom[0] = 16'h1234; rom[1] = 16'h1235; rom[2] = 16'hE000;
        log_q.delete();
        pulse_start();
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_retired", bus.retired, 0);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
            dc_mode = 2;
            log_q.delete();
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
                pulse_start();
            end
            wait_stop(300, ok);
            if (!ok) do_reset();
            @(negedge clk);
        end
        dc_mode = 0;

        @(posedge clk) #1 bus2.start = 1'b1;
        @(posedge clk) #1 bus2.start = 1'b0;
        @(negedge clk);
        chk("wrap_addr", bus2.rom_addr, 12'hFFF);
        chk("wrap_busy", bus2.busy, 1);
        @(negedge clk);
        chk("wrap_ee", bus2.execution_enable, 1);
        chk("wrap_instr", bus2.instruction, 16'h1000);
        chk("wrap_npc", bus2.next_program_counter, 12'h000);
        chk("wrap_nsp", bus2.next_stack_pointer, 0);
        @(negedge clk);
        chk("wrap_addr2", bus2.rom_addr, 12'h000);
        @(negedge clk);
        chk("wrap_halt_ee", bus2.execution_enable, 0);
        @(negedge clk);
        chk("wrap_halted", bus2.halted, 1);
        chk("wrap_retired", bus2.retired, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
